// File: rtl/hs32_prefetch_if.sv
// ============================================================================
// Module  : hs32_prefetch_if
// Brief   : Arbiter and decode bus bundle for the hs32 instruction prefetch queue.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface hs32_prefetch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dtr;
  logic              reqm;
  logic              rdym;
  logic [DATA_W-1:0] instd;
  logic [ADDR_W-1:0] pcd;
  logic              reqd;
  logic              rdyd;
  logic [ADDR_W-1:0] newpc;
  logic              flush;

  modport master (
    output addr, reqm, instd, pcd, rdyd,
    input  dtr, rdym, reqd, newpc, flush
  );

  modport slave (
    input  addr, reqm, instd, pcd, rdyd,
    output dtr, rdym, reqd, newpc, flush
  );
endinterface

`default_nettype wire

// File: rtl/hs32_prefetch.sv
// ============================================================================
// Module  : hs32_prefetch
// Brief   : DEPTH-entry instruction prefetch FIFO with flush/drain handling.
//           Optional same-cycle fetch bypass enabled by macro FETCH_BYPASS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hs32_prefetch #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rstn,
  hs32_prefetch_if.master      bus
);
  localparam int                PTR_W   = $clog2(DEPTH) + 1;
  localparam int                IDX_W   = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]  DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(DATA_W / 8);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [ADDR_W-1:0] pend_pc, pend_pc_next;
  logic [PTR_W-1:0]  wp, wp_next;
  logic [PTR_W-1:0]  rp, rp_next;
  logic [PTR_W-1:0]  fill;
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic              full;
  logic              head_valid;
  logic              beat;
  logic              push;
  logic              pop;
  logic              bypass_hit;
  logic              bypass_take;

  assign fill       = wp - rp;
  assign full       = (fill == DEPTH_P);
  assign head_valid = (fill != '0) && (state == RUN);

  // In DRAIN the old pc is still on the bus, so addr stays put until rdym.
  assign bus.reqm = (state == DRAIN) || !full;
  assign bus.addr = pc;
  assign beat     = bus.reqm && bus.rdym;

`ifdef FETCH_BYPASS_EN
  assign bypass_hit  = (state == RUN) && (fill == '0) && beat && !bus.flush;
  assign bypass_take = bypass_hit && bus.reqd;
  assign bus.rdyd    = head_valid || bypass_hit;
  assign bus.instd   = bypass_hit ? bus.dtr  : q_data[rp[IDX_W-1:0]];
  assign bus.pcd     = bypass_hit ? bus.addr : q_pc[rp[IDX_W-1:0]];
`else
  assign bypass_hit  = 1'b0;
  assign bypass_take = 1'b0;
  assign bus.rdyd    = head_valid;
  assign bus.instd   = q_data[rp[IDX_W-1:0]];
  assign bus.pcd     = q_pc[rp[IDX_W-1:0]];
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pend_pc_next = pend_pc;
    wp_next      = wp;
    rp_next      = rp;
    push         = 1'b0;
    pop          = 1'b0;
    case (state)
      RUN: begin
        if (bus.flush) begin
          wp_next = '0;
          rp_next = '0;
          // A beat still in flight must be retired before the bus may move on.
          if (bus.reqm && !bus.rdym) begin
            state_next   = DRAIN;
            pend_pc_next = bus.newpc;
          end else begin
            pc_next = bus.newpc;
          end
        end else begin
          push = beat && !bypass_take;
          pop  = head_valid && bus.reqd;
          if (beat) pc_next = pc + PC_STEP;
          if (push) wp_next = wp + PTR_ONE;
          if (pop)  rp_next = rp + PTR_ONE;
        end
      end
      DRAIN: begin
        if (bus.flush) pend_pc_next = bus.newpc;
        if (bus.rdym) begin
          pc_next    = bus.flush ? bus.newpc : pend_pc;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc      <= RESET_PC;
      pend_pc <= RESET_PC;
      wp      <= '0;
      rp      <= '0;
    end else begin
      pc      <= pc_next;
      pend_pc <= pend_pc_next;
      wp      <= wp_next;
      rp      <= rp_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (push) begin
      q_data[wp[IDX_W-1:0]] <= bus.dtr;
      q_pc[wp[IDX_W-1:0]]   <= pc;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_hs32_prefetch.sv
// ============================================================================
// Module  : tb_hs32_prefetch
// Brief   : Directed self-checking bench for hs32_prefetch (honours FETCH_BYPASS_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hs32_prefetch;
  logic clk;
  logic rstn;
  logic        dtr_ovr_en;
  logic [31:0] dtr_ovr;
  int n_vec;
  int n_err;

  hs32_prefetch_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  hs32_prefetch #(
    .DATA_W  (32),
    .ADDR_W  (32),
    .DEPTH   (4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  // Memory image: word at address a reads as 0xA0000000 | a.
  assign bus.dtr = dtr_ovr_en ? dtr_ovr : (32'hA000_0000 | bus.addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    dtr_ovr_en = 1'b0;
    dtr_ovr    = '0;
    rstn       = 1'b0;
    bus.rdym   = 1'b0;
    bus.reqd   = 1'b0;
    bus.flush  = 1'b0;
    bus.newpc  = '0;

    #2;
    check("rst_reqm",  32'(bus.reqm), 32'd1);
    check("rst_addr",  bus.addr,      32'h0);
    check("rst_rdyd",  32'(bus.rdyd), 32'd0);
    check("rst_instd", bus.instd,     32'h0);
    check("rst_pcd",   bus.pcd,       32'h0);

    // Stream into an idle decoder until the queue fills.
    @(negedge clk);
    rstn     = 1'b1;
    bus.rdym = 1'b1;
    tick();
    check("fill1_rdyd",  32'(bus.rdyd), 32'd1);
    check("fill1_instd", bus.instd,     32'hA000_0000);
    check("fill1_pcd",   bus.pcd,       32'h0);
    check("fill1_addr",  bus.addr,      32'h4);
    tick(); tick(); tick();
    check("full_reqm",  32'(bus.reqm), 32'd0);
    check("full_addr",  bus.addr,      32'h10);
    tick();
    check("full_hold_addr", bus.addr,  32'h10);
    check("full_instd", bus.instd,     32'hA000_0000);

    // Drain with concurrent refill: pops must come out strictly sequential.
    bus.reqd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("pop_rdyd",  32'(bus.rdyd), 32'd1);
      check("pop_pcd",   bus.pcd,       32'(i * 4));
      check("pop_instd", bus.instd,     32'hA000_0000 | 32'(i * 4));
      tick();
    end
    bus.reqd = 1'b0;
    check("after_pop_pcd",  bus.pcd,  32'h18);
    check("after_pop_addr", bus.addr, 32'h24);

    // Flush while a beat is stalled, re-flush inside DRAIN, then retire it.
    bus.rdym  = 1'b0;
    bus.flush = 1'b1;
    bus.newpc = 32'h100;
    tick();
    check("drain_addr", bus.addr,      32'h24);
    check("drain_reqm", 32'(bus.reqm), 32'd1);
    check("drain_rdyd", 32'(bus.rdyd), 32'd0);
    bus.newpc = 32'h200;
    tick();
    check("drain2_addr", bus.addr,      32'h24);
    check("drain2_rdyd", 32'(bus.rdyd), 32'd0);
    bus.flush = 1'b0;
    bus.rdym  = 1'b1;
    tick();
    bus.rdym = 1'b0;
    #1;
    check("post_drain_addr", bus.addr,      32'h200);
    check("post_drain_reqm", 32'(bus.reqm), 32'd1);
    check("post_drain_rdyd", 32'(bus.rdyd), 32'd0);

    // One push, then flush coinciding with pop and beat.
    @(negedge clk);
    bus.rdym = 1'b1;
    tick();
    check("one_rdyd", 32'(bus.rdyd), 32'd1);
    check("one_pcd",  bus.pcd,       32'h200);
    bus.reqd  = 1'b1;
    bus.flush = 1'b1;
    bus.newpc = 32'h300;
    tick();
    bus.flush = 1'b0;
    bus.reqd  = 1'b0;
    bus.rdym  = 1'b0;
    #1;
    check("flpop_rdyd", 32'(bus.rdyd), 32'd0);
    check("flpop_addr", bus.addr,      32'h300);
    @(negedge clk);
    check("flpop_empty", 32'(bus.rdyd), 32'd0);

    // Asynchronous reset in the middle of streaming.
    bus.rdym = 1'b1;
    tick(); tick();
    check("mid_addr", bus.addr, 32'h308);
    bus.rdym = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check("arst_reqm",  32'(bus.reqm), 32'd1);
    check("arst_addr",  bus.addr,      32'h0);
    check("arst_rdyd",  32'(bus.rdyd), 32'd0);
    check("arst_instd", bus.instd,     32'h0);
    @(negedge clk);
    rstn     = 1'b1;
    bus.rdym = 1'b1;
    tick();
    check("restart_pcd",   bus.pcd,   32'h0);
    check("restart_instd", bus.instd, 32'hA000_0000);
    check("restart_addr",  bus.addr,  32'h4);

    // Flush with a completing beat (discarded), then fetch into an empty queue.
    bus.flush = 1'b1;
    bus.newpc = 32'h20;
    tick();
    bus.flush  = 1'b0;
    bus.reqd   = 1'b1;
    dtr_ovr_en = 1'b1;
    dtr_ovr    = 32'hDEAD_BEEF;
    #1;
`ifdef FETCH_BYPASS_EN
    check("byp_rdyd",  32'(bus.rdyd), 32'd1);
    check("byp_instd", bus.instd,     32'hDEAD_BEEF);
    check("byp_pcd",   bus.pcd,       32'h20);
`else
    check("nobyp_rdyd", 32'(bus.rdyd), 32'd0);
`endif
    tick();
    check("byp_next_addr", bus.addr, 32'h24);
    bus.rdym   = 1'b0;
    bus.reqd   = 1'b0;
    dtr_ovr_en = 1'b0;
    #1;
`ifdef FETCH_BYPASS_EN
    check("byp_fill0", 32'(bus.rdyd), 32'd0);
`else
    check("nobyp_rdyd2", 32'(bus.rdyd), 32'd1);
    check("nobyp_instd", bus.instd,     32'hDEAD_BEEF);
    check("nobyp_pcd",   bus.pcd,       32'h20);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
